// File: rtl/axil_ctrl_master_if.sv
// -----------------------------------------------------------------------------
// axil_ctrl_master_if
// Purpose : AXI4-Lite bus bundle between the control-side initiator
//           (axil_ctrl_master) and a tile's control_S_AXI_* slave port.
// Params  : BW        data width in bits
//           AXI_ADDR  address width in bits
// Modports: master  - drives AW/W/AR channels and BREADY/RREADY
//           slave   - drives AWREADY/WREADY/ARREADY and the B/R channels
// -----------------------------------------------------------------------------
interface axil_ctrl_master_if #(
    parameter int BW       = 32,
    parameter int AXI_ADDR = 8
);
    localparam int BWB = BW / 8;

    // Write address channel
    logic [AXI_ADDR-1:0] m_AXI_AWADDR;
    logic                m_AXI_AWVALID;
    logic                m_AXI_AWREADY;
    // Write data channel
    logic [BW-1:0]       m_AXI_WDATA;
    logic [BWB-1:0]      m_AXI_WSTRB;
    logic                m_AXI_WVALID;
    logic                m_AXI_WREADY;
    // Write response channel
    logic [1:0]          m_AXI_BRESP;
    logic                m_AXI_BVALID;
    logic                m_AXI_BREADY;
    // Read address channel
    logic [AXI_ADDR-1:0] m_AXI_ARADDR;
    logic                m_AXI_ARVALID;
    logic                m_AXI_ARREADY;
    // Read data channel
    logic [BW-1:0]       m_AXI_RDATA;
    logic [1:0]          m_AXI_RRESP;
    logic                m_AXI_RVALID;
    logic                m_AXI_RREADY;

    modport master (
        output m_AXI_AWADDR, m_AXI_AWVALID, input  m_AXI_AWREADY,
        output m_AXI_WDATA,  m_AXI_WSTRB,   m_AXI_WVALID, input m_AXI_WREADY,
        input  m_AXI_BRESP,  m_AXI_BVALID,  output m_AXI_BREADY,
        output m_AXI_ARADDR, m_AXI_ARVALID, input  m_AXI_ARREADY,
        input  m_AXI_RDATA,  m_AXI_RRESP,   m_AXI_RVALID, output m_AXI_RREADY
    );

    modport slave (
        input  m_AXI_AWADDR, m_AXI_AWVALID, output m_AXI_AWREADY,
        input  m_AXI_WDATA,  m_AXI_WSTRB,   m_AXI_WVALID, output m_AXI_WREADY,
        output m_AXI_BRESP,  m_AXI_BVALID,  input  m_AXI_BREADY,
        input  m_AXI_ARADDR, m_AXI_ARVALID, output m_AXI_ARREADY,
        output m_AXI_RDATA,  m_AXI_RRESP,   m_AXI_RVALID, input m_AXI_RREADY
    );
endinterface

// File: rtl/axil_ctrl_master.sv
// -----------------------------------------------------------------------------
// axil_ctrl_master
// Purpose : AXI4-Lite initiator for programming a tile's control registers.
//           Takes one read/write command at a time on a valid/ready command
//           port, runs a single AXI-Lite transaction, and returns data and
//           response on a valid/ready response port.
// Ports   : clk_control, clk_control_rst_low (async assert, active low)
//           cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb
//           rsp_valid/rsp_ready, rsp_rdata, rsp_resp, rsp_write
//           m_axi : axil_ctrl_master_if.master (AW/W/B/AR/R channels)
// Config  : define AXIL_MASTER_TIMEOUT_EN to add a TO_W-bit watchdog that
//           aborts a stuck transaction with DECERR (2'b11). Without it the
//           block waits indefinitely for the slave.
// -----------------------------------------------------------------------------
module axil_ctrl_master #(
    parameter int BW       = 32,
    parameter int BWB      = BW / 8,
    parameter int AXI_ADDR = 8
`ifdef AXIL_MASTER_TIMEOUT_EN
    ,
    parameter int TO_W     = 16
`endif
) (
    input  logic                clk_control,
    input  logic                clk_control_rst_low,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AXI_ADDR-1:0] cmd_addr,
    input  logic [BW-1:0]       cmd_wdata,
    input  logic [BWB-1:0]      cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [BW-1:0]       rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_write,
    axil_ctrl_master_if.master  m_axi
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WR_B  = 3'd2,
        S_RD_AR = 3'd3,
        S_RD_R  = 3'd4,
        S_RSP   = 3'd5
    } state_t;

    state_t              state_q,     state_d;
    logic [AXI_ADDR-1:0] awaddr_q,    awaddr_d;
    logic [AXI_ADDR-1:0] araddr_q,    araddr_d;
    logic [BW-1:0]       wdata_q,     wdata_d;
    logic [BWB-1:0]      wstrb_q,     wstrb_d;
    logic                awvalid_q,   awvalid_d;
    logic                wvalid_q,    wvalid_d;
    logic                bready_q,    bready_d;
    logic                arvalid_q,   arvalid_d;
    logic                rready_q,    rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [BW-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q,  rsp_resp_d;
    logic                rsp_write_q, rsp_write_d;
    logic                aw_done_s;
    logic                w_done_s;
`ifdef AXIL_MASTER_TIMEOUT_EN
    logic [TO_W-1:0]     to_cnt_q,    to_cnt_d;
`endif

    // A channel counts as done once its VALID is already low, or it is
    // handshaking this cycle; AW and W never wait on each other.
    assign aw_done_s = !awvalid_q || m_axi.m_AXI_AWREADY;
    assign w_done_s  = !wvalid_q  || m_axi.m_AXI_WREADY;

    assign cmd_ready = (state_q == S_IDLE);

    assign m_axi.m_AXI_AWADDR  = awaddr_q;
    assign m_axi.m_AXI_AWVALID = awvalid_q;
    assign m_axi.m_AXI_WDATA   = wdata_q;
    assign m_axi.m_AXI_WSTRB   = wstrb_q;
    assign m_axi.m_AXI_WVALID  = wvalid_q;
    assign m_axi.m_AXI_BREADY  = bready_q;
    assign m_axi.m_AXI_ARADDR  = araddr_q;
    assign m_axi.m_AXI_ARVALID = arvalid_q;
    assign m_axi.m_AXI_RREADY  = rready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_resp            = rsp_resp_q;
    assign rsp_write           = rsp_write_q;

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
`ifdef AXIL_MASTER_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rsp_write_d = cmd_write;
`ifdef AXIL_MASTER_TIMEOUT_EN
                    to_cnt_d    = {TO_W{1'b0}};
`endif
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_AR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                if (awvalid_q && m_axi.m_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && m_axi.m_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (aw_done_s && w_done_s) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end else begin
                    state_d  = S_WR;
                end
            end
            S_WR_B: begin
                if (m_axi.m_AXI_BVALID) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi.m_AXI_BRESP;
                    rsp_rdata_d = {BW{1'b0}};
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    state_d     = S_WR_B;
                end
            end
            S_RD_AR: begin
                if (m_axi.m_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end else begin
                    state_d   = S_RD_AR;
                end
            end
            S_RD_R: begin
                if (m_axi.m_AXI_RVALID) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi.m_AXI_RDATA;
                    rsp_resp_d  = m_axi.m_AXI_RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    state_d     = S_RD_R;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d     = S_RSP;
                end
            end
            default: begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
        // Watchdog: a transaction completing on the expiry cycle keeps its
        // real response; otherwise the bus is released and DECERR reported.
        if ((state_q == S_WR) || (state_q == S_WR_B) ||
            (state_q == S_RD_AR) || (state_q == S_RD_R)) begin
            to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            if ((&to_cnt_q) && (state_d != S_RSP)) begin
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_resp_d  = 2'b11;
                rsp_rdata_d = {BW{1'b0}};
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end else begin
                state_d     = state_d;
            end
        end else begin
            to_cnt_d = to_cnt_d;
        end
`endif
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            state_q     <= S_IDLE;
            awaddr_q    <= {AXI_ADDR{1'b0}};
            araddr_q    <= {AXI_ADDR{1'b0}};
            wdata_q     <= {BW{1'b0}};
            wstrb_q     <= {BWB{1'b0}};
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {BW{1'b0}};
            rsp_resp_q  <= 2'b00;
            rsp_write_q <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            to_cnt_q    <= {TO_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
`ifdef AXIL_MASTER_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axil_ctrl_master.sv
// -----------------------------------------------------------------------------
// tb_axil_ctrl_master
// Directed bench for axil_ctrl_master. The bench plays the AXI-Lite slave
// with fixed, cycle-exact READY/VALID timing and checks every DUT output
// against hand-computed values one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_axil_ctrl_master;

    logic        clk_control;
    logic        clk_control_rst_low;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;

    int n_vec;
    int n_miss;

    axil_ctrl_master_if #(.BW(32), .AXI_ADDR(8)) axi_if ();

`ifdef AXIL_MASTER_TIMEOUT_EN
    axil_ctrl_master #(.BW(32), .BWB(4), .AXI_ADDR(8), .TO_W(4)) dut (
`else
    axil_ctrl_master #(.BW(32), .BWB(4), .AXI_ADDR(8)) dut (
`endif
        .clk_control         (clk_control),
        .clk_control_rst_low (clk_control_rst_low),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_write           (cmd_write),
        .cmd_addr            (cmd_addr),
        .cmd_wdata           (cmd_wdata),
        .cmd_wstrb           (cmd_wstrb),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_rdata           (rsp_rdata),
        .rsp_resp            (rsp_resp),
        .rsp_write           (rsp_write),
        .m_axi               (axi_if)
    );

    // 10-unit control clock.
    initial clk_control = 1'b0;
    always #5 clk_control = ~clk_control;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_control);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        clk_control_rst_low = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        axi_if.m_AXI_AWREADY = 1'b0;
        axi_if.m_AXI_WREADY  = 1'b0;
        axi_if.m_AXI_BRESP   = 2'b00;
        axi_if.m_AXI_BVALID  = 1'b0;
        axi_if.m_AXI_ARREADY = 1'b0;
        axi_if.m_AXI_RDATA   = 32'h0;
        axi_if.m_AXI_RRESP   = 2'b00;
        axi_if.m_AXI_RVALID  = 1'b0;

        tick();
        tick();
        clk_control_rst_low = 1'b1;
        tick();

        // ---- reset state, with a stray BVALID that must be ignored ----
        axi_if.m_AXI_BVALID = 1'b1;
        #1;
        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("rst_valids", {27'd0, axi_if.m_AXI_AWVALID, axi_if.m_AXI_WVALID,
                  axi_if.m_AXI_ARVALID, axi_if.m_AXI_BREADY, axi_if.m_AXI_RREADY}, 32'd0);
        check_val("rst_rsp", {rsp_rdata[28:0], rsp_resp, rsp_valid}, 32'd0);
        check_val("rst_addr", {16'd0, axi_if.m_AXI_AWADDR, axi_if.m_AXI_ARADDR}, 32'd0);
        check_val("rst_wdata", axi_if.m_AXI_WDATA, 32'd0);
        axi_if.m_AXI_BVALID = 1'b0;

        // ---- T0: write 0x04 <- 0xDEADBEEF, zero-wait slave ----
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04;
        cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        axi_if.m_AXI_AWREADY = 1'b1;
        axi_if.m_AXI_WREADY  = 1'b1;
        tick();
        // T1
        cmd_valid = 1'b0;
        check_val("wr_t1_awvalid", {31'd0, axi_if.m_AXI_AWVALID}, 32'd1);
        check_val("wr_t1_wvalid", {31'd0, axi_if.m_AXI_WVALID}, 32'd1);
        check_val("wr_t1_awaddr", {24'd0, axi_if.m_AXI_AWADDR}, 32'h04);
        check_val("wr_t1_wdata", axi_if.m_AXI_WDATA, 32'hDEADBEEF);
        check_val("wr_t1_wstrb", {28'd0, axi_if.m_AXI_WSTRB}, 32'hF);
        check_val("wr_t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        // T2: both channels done, waiting for B
        check_val("wr_t2_valids", {30'd0, axi_if.m_AXI_AWVALID, axi_if.m_AXI_WVALID}, 32'd0);
        check_val("wr_t2_bready", {31'd0, axi_if.m_AXI_BREADY}, 32'd1);
        check_val("wr_t2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        axi_if.m_AXI_AWREADY = 1'b0;
        axi_if.m_AXI_WREADY  = 1'b0;
        axi_if.m_AXI_BVALID  = 1'b1;
        axi_if.m_AXI_BRESP   = 2'b00;
        tick();
        // T3: response presented; queue a read that must wait until T4
        axi_if.m_AXI_BVALID = 1'b0;
        check_val("wr_t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("wr_t3_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        check_val("wr_t3_rsp_rdata", rsp_rdata, 32'd0);
        check_val("wr_t3_rsp_write", {31'd0, rsp_write}, 32'd1);
        check_val("wr_t3_bready", {31'd0, axi_if.m_AXI_BREADY}, 32'd0);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
        tick();
        // T4: back in IDLE, read accepted on this edge
        check_val("b2b_t4_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("b2b_t4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        cmd_valid = 1'b0;

        // ---- read 0x08, ARREADY delayed 3 cycles -> ARVALID for 4 cycles ----
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rd_arvalid_%0d", i), {31'd0, axi_if.m_AXI_ARVALID}, 32'd1);
            check_val($sformatf("rd_araddr_%0d", i), {24'd0, axi_if.m_AXI_ARADDR}, 32'h08);
            axi_if.m_AXI_ARREADY = (i == 3) ? 1'b1 : 1'b0;
            tick();
        end
        axi_if.m_AXI_ARREADY = 1'b0;
        check_val("rd_arvalid_drop", {31'd0, axi_if.m_AXI_ARVALID}, 32'd0);
        check_val("rd_rready", {31'd0, axi_if.m_AXI_RREADY}, 32'd1);
        axi_if.m_AXI_RVALID = 1'b1;
        axi_if.m_AXI_RDATA  = 32'h00000012;
        axi_if.m_AXI_RRESP  = 2'b00;
        tick();
        axi_if.m_AXI_RVALID = 1'b0;
        check_val("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("rd_rsp_rdata", rsp_rdata, 32'h12);
        check_val("rd_rsp_write", {31'd0, rsp_write}, 32'd0);
        check_val("rd_rsp_resp", {30'd0, rsp_resp}, 32'd0);
        check_val("rd_rready_drop", {31'd0, axi_if.m_AXI_RREADY}, 32'd0);
        tick();
        check_val("rd_rsp_done", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        // ---- write: WREADY in WR cycle 5, AWREADY in WR cycle 7, BRESP=SLVERR ----
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h10;
        cmd_wdata = 32'h0000A5A5; cmd_wstrb = 4'h3;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("skew_awvalid_%0d", k), {31'd0, axi_if.m_AXI_AWVALID}, 32'd1);
            check_val($sformatf("skew_wvalid_%0d", k), {31'd0, axi_if.m_AXI_WVALID},
                      (k <= 5) ? 32'd1 : 32'd0);
            check_val($sformatf("skew_bready_%0d", k), {31'd0, axi_if.m_AXI_BREADY}, 32'd0);
            axi_if.m_AXI_WREADY  = (k == 5) ? 1'b1 : 1'b0;
            axi_if.m_AXI_AWREADY = (k == 7) ? 1'b1 : 1'b0;
            tick();
        end
        axi_if.m_AXI_AWREADY = 1'b0;
        axi_if.m_AXI_WREADY  = 1'b0;
        check_val("skew_bready", {31'd0, axi_if.m_AXI_BREADY}, 32'd1);
        check_val("skew_valids_low", {30'd0, axi_if.m_AXI_AWVALID, axi_if.m_AXI_WVALID}, 32'd0);
        axi_if.m_AXI_BVALID = 1'b1;
        axi_if.m_AXI_BRESP  = 2'b10;
        tick();
        axi_if.m_AXI_BVALID = 1'b0;
        axi_if.m_AXI_BRESP  = 2'b00;

        // ---- stall in RSP for 10 cycles with a new command pending ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h0C;
        for (int s = 0; s < 10; s++) begin
            check_val($sformatf("stall_rsp_valid_%0d", s), {31'd0, rsp_valid}, 32'd1);
            check_val($sformatf("stall_resp_%0d", s), {30'd0, rsp_resp}, 32'h2);
            check_val($sformatf("stall_rdata_%0d", s), rsp_rdata, 32'd0);
            check_val($sformatf("stall_cmd_ready_%0d", s), {31'd0, cmd_ready}, 32'd0);
            check_val($sformatf("stall_axi_idle_%0d", s), {29'd0, axi_if.m_AXI_ARVALID,
                      axi_if.m_AXI_AWVALID, axi_if.m_AXI_BREADY}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("stall_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check_val("stall_arvalid", {31'd0, axi_if.m_AXI_ARVALID}, 32'd1);
        check_val("stall_araddr", {24'd0, axi_if.m_AXI_ARADDR}, 32'h0C);
        axi_if.m_AXI_ARREADY = 1'b1;
        tick();
        axi_if.m_AXI_ARREADY = 1'b0;
        check_val("rst_mid_rready", {31'd0, axi_if.m_AXI_RREADY}, 32'd1);

        // ---- reset asserted in RD_R: RREADY drops at once, no response ----
        clk_control_rst_low = 1'b0;
        #1;
        check_val("rst_mid_rready_drop", {31'd0, axi_if.m_AXI_RREADY}, 32'd0);
        tick();
        clk_control_rst_low = 1'b1;
        axi_if.m_AXI_RVALID = 1'b1;
        axi_if.m_AXI_RDATA  = 32'h55AA55AA;
        for (int r = 0; r < 3; r++) begin
            tick();
            check_val($sformatf("rst_after_rsp_valid_%0d", r), {31'd0, rsp_valid}, 32'd0);
            check_val($sformatf("rst_after_rready_%0d", r), {31'd0, axi_if.m_AXI_RREADY}, 32'd0);
            check_val($sformatf("rst_after_cmd_ready_%0d", r), {31'd0, cmd_ready}, 32'd1);
        end
        axi_if.m_AXI_RVALID = 1'b0;

`ifdef AXIL_MASTER_TIMEOUT_EN
        // ---- watchdog: ARREADY never comes, TO_W=4 ----
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20;
        tick();
        cmd_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check_val($sformatf("to_arvalid_%0d", c), {31'd0, axi_if.m_AXI_ARVALID}, 32'd1);
            check_val($sformatf("to_rsp_valid_%0d", c), {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        check_val("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("to_rsp_resp", {30'd0, rsp_resp}, 32'h3);
        check_val("to_rsp_rdata", rsp_rdata, 32'd0);
        check_val("to_arvalid", {31'd0, axi_if.m_AXI_ARVALID}, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_val("to_idle", {31'd0, cmd_ready}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
